// File: rtl/counter_pkg.sv
// counter_pkg: constants shared by the key_event_counter slice.
//   SEG_W    segments per hex digit
//   DEB_W()  width of a debounce counter able to hold 0..DEB_CYCLES
//   KEY_CNT  index of the count/latch button in key_i
//   KEY_CLR  index of the clear button in key_i
package counter_pkg;

  localparam int SEG_W   = 7;
  localparam int KEY_CNT = 0;
  localparam int KEY_CLR = 1;

  function automatic int DEB_W(input int deb_cycles);
    return $clog2(deb_cycles + 1);
  endfunction

endpackage

// File: rtl/key_event_counter_if.sv
// key_event_counter_if: board-side signal bundle of key_event_counter.
//   sw_i    switch bank (asynchronous)
//   key_i   buttons, active-high, [0]=count/latch, [1]=clear
//   ledr_o  switch value latched by the last count press
//   cnt_o   press count
//   hex_o   7 segments per hex digit of cnt_o, digit 0 least significant
// master drives the inputs (board / bench), slave is the counter.
interface key_event_counter_if #(
  parameter int CNT_W = 8,
  parameter int SW_W  = 10
);
  import counter_pkg::*;

  localparam int DIGITS = CNT_W / 4;

  logic [SW_W-1:0]         sw_i;
  logic [1:0]              key_i;
  logic [SW_W-1:0]         ledr_o;
  logic [CNT_W-1:0]        cnt_o;
  logic [SEG_W*DIGITS-1:0] hex_o;

  modport master (output sw_i, key_i, input ledr_o, cnt_o, hex_o);
  modport slave  (input sw_i, key_i, output ledr_o, cnt_o, hex_o);

endinterface

// File: rtl/dec_hex.sv
// dec_hex: hex nibble to 7-segment decoder, active-low segments
// (bit 0 = segment a ... bit 6 = segment g), as on the lab board.
//   hex_i  nibble to display
//   seg_o  segment drive, 0 lights a segment
module dec_hex (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives seg_o and no latch is inferred.
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/key_debounce.sv
// key_debounce: one button input path: 2-FF synchroniser, debounce,
// rising-edge detect.
//   clk100_i  system clock
//   rst_i     asynchronous reset, active-high
//   key_i     raw button, active-high, asynchronous
//   press_o   one-cycle pulse when the debounced key goes high
// The key state only follows the synchronised input after DEB_CYCLES
// consecutive samples that disagree with it; any agreeing sample restarts
// the count, so shorter glitches are ignored.
module key_debounce
  import counter_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk100_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o
);

  localparam int DW = DEB_W(DEB_CYCLES);

  logic          s1, s2;
  logic          state, state_d;
  logic [DW-1:0] dcnt;

  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      state   <= 1'b0;
      state_d <= 1'b0;
      dcnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values (s2 gets the old s1).
      s1      <= key_i;
      s2      <= s1;
      state_d <= state;
      if (s2 == state) begin
        dcnt <= '0;
      end else if (dcnt == DW'(DEB_CYCLES - 1)) begin
        state <= s2;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  // Release edges are deliberately not reported.
  assign press_o = state & ~state_d;

endmodule

// File: rtl/key_event_counter.sv
// key_event_counter: counts debounced presses of key 0, latches the switch
// bank onto the LEDs on each such press, clears both on a press of key 1,
// and shows the count on CNT_W/4 hex digits.
//   clk100_i  100 MHz system clock
//   rst_i     asynchronous reset, active-high (release expected synchronous)
//   bus       key_event_counter_if.slave: sw_i, key_i in; ledr_o, cnt_o, hex_o out
// Build option: define COUNTER_SAT_EN to make cnt_o saturate at all-ones
// instead of wrapping; LED latching and clear are unaffected.
module key_event_counter
  import counter_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int SW_W       = 10,
  parameter int DEB_CYCLES = 4
) (
  input  logic                 clk100_i,
  input  logic                 rst_i,
  key_event_counter_if.slave   bus
);

  localparam int DIGITS = CNT_W / 4;

  logic [1:0]              press;
  logic [CNT_W-1:0]        cnt_q;
  logic [SW_W-1:0]         ledr_q;
  logic [SEG_W*DIGITS-1:0] hex_w;

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
      .clk100_i (clk100_i),
      .rst_i    (rst_i),
      .key_i    (bus.key_i[k]),
      .press_o  (press[k])
    );
  end

  // Clear has priority: a count press in the same cycle is dropped.
  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      ledr_q <= '0;
    end else if (press[KEY_CLR]) begin
      cnt_q  <= '0;
      ledr_q <= '0;
    end else if (press[KEY_CNT]) begin
      ledr_q <= bus.sw_i;
`ifdef COUNTER_SAT_EN
      if (cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
`else
      cnt_q <= cnt_q + CNT_W'(1);
`endif
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    dec_hex u_dec_hex (
      .hex_i (cnt_q[4*k +: 4]),
      .seg_o (hex_w[SEG_W*k +: SEG_W])
    );
  end

  assign bus.cnt_o  = cnt_q;
  assign bus.ledr_o = ledr_q;
  assign bus.hex_o  = hex_w;

endmodule
